bus_ctrl: RTL and testbench

BUS_CTRL -- requirements
Module: bus_ctrl

---
 rtl/bus_pkg.sv | 24 ++
 rtl/bus_if.sv | 32 +++
 rtl/bus_addr_decode.sv | 26 ++
 rtl/bus_ctrl.sv | 123 ++++++++++++
 tb/tb_bus_ctrl.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the bus controller: region map, slave count,
// FSM state encoding and the read value returned on error completions.
package bus_pkg;

  localparam int NUM_SLAVES = 4;
  localparam int ADR_W      = 32;
  localparam int DAT_W      = 32;

  // Address regions selected by adr[31:28]; anything above UART is unmapped
  localparam logic [3:0] REGION_ROM  = 4'h0;
  localparam logic [3:0] REGION_RAM  = 4'h1;
  localparam logic [3:0] REGION_GPIO = 4'h2;
  localparam logic [3:0] REGION_UART = 4'h3;

  // Data handed back to the master on unmapped or timed-out accesses
  localparam logic [DAT_W-1:0] ERR_RDATA = '0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/bus_if.sv
// Bus bundle between one master, the controller and four slaves.
// The slave modport is the controller's view (it is the target of the master
// and drives the slave-side strobes); the master modport is the opposite view
// used by whatever sits around the controller.
interface bus_if;
  import bus_pkg::*;

  logic                        m_stb_i;
  logic                        m_we_i;
  logic [ADR_W-1:0]            m_adr_i;
  logic [DAT_W-1:0]            m_dat_i;
  logic [DAT_W-1:0]            m_dat_o;
  logic                        m_ack_o;
  logic                        m_err_o;
  logic [NUM_SLAVES-1:0]       s_stb_o;
  logic                        s_we_o;
  logic [ADR_W-1:0]            s_adr_o;
  logic [DAT_W-1:0]            s_dat_o;
  logic [NUM_SLAVES*DAT_W-1:0] s_dat_i;
  logic [NUM_SLAVES-1:0]       s_ack_i;

  modport slave (
    input  m_stb_i, m_we_i, m_adr_i, m_dat_i, s_dat_i, s_ack_i,
    output m_dat_o, m_ack_o, m_err_o, s_stb_o, s_we_o, s_adr_o, s_dat_o
  );

  modport master (
    output m_stb_i, m_we_i, m_adr_i, m_dat_i, s_dat_i, s_ack_i,
    input  m_dat_o, m_ack_o, m_err_o, s_stb_o, s_we_o, s_adr_o, s_dat_o
  );

endinterface

// File: rtl/bus_addr_decode.sv
// Combinational region decoder: adr[31:28] to one-hot slave select,
// binary slave index and a mapped/unmapped flag.
module bus_addr_decode
  import bus_pkg::*;
(
  input  logic [3:0]            region,
  output logic [NUM_SLAVES-1:0] onehot,
  output logic [1:0]            idx,
  output logic                  valid
);

  // Map each region to its slave; unmapped regions select nothing
  always_comb begin
    onehot = '0;
    idx    = 2'd0;
    valid  = 1'b0;
    case (region)
      REGION_ROM:  begin onehot = 4'b0001; idx = 2'd0; valid = 1'b1; end
      REGION_RAM:  begin onehot = 4'b0010; idx = 2'd1; valid = 1'b1; end
      REGION_GPIO: begin onehot = 4'b0100; idx = 2'd2; valid = 1'b1; end
      REGION_UART: begin onehot = 4'b1000; idx = 2'd3; valid = 1'b1; end
      default:     ;
    endcase
  end

endmodule

// File: rtl/bus_ctrl.sv
// Single-master, four-slave bus controller (IDLE -> ACCESS -> DONE).
// Optional access timeout enabled by defining BUS_TIMEOUT_EN; without it the
// controller waits in ACCESS until the selected slave acknowledges.
module bus_ctrl
  import bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  bus_if.slave bus
);

  state_e                state, state_nxt;
  logic [NUM_SLAVES-1:0] sel_oh;
  logic [1:0]            sel_idx;
  logic                  err_q;
  logic                  s_we_q;
  logic [ADR_W-1:0]      s_adr_q;
  logic [DAT_W-1:0]      s_dat_q;
  logic [DAT_W-1:0]      m_dat_q;

  logic [NUM_SLAVES-1:0] dec_oh;
  logic [1:0]            dec_idx;
  logic                  dec_valid;
  logic                  accept;
  logic                  sel_ack;
  logic [DAT_W-1:0]      sel_rdata;
  logic                  timeout_hit;

  bus_addr_decode u_dec (
    .region (bus.m_adr_i[31:28]),
    .onehot (dec_oh),
    .idx    (dec_idx),
    .valid  (dec_valid)
  );

  // New requests are only taken in IDLE; acks only matter for the latched slave
  assign accept    = (state == ST_IDLE) && bus.m_stb_i;
  assign sel_ack   = bus.s_ack_i[sel_idx];
  assign sel_rdata = bus.s_dat_i[{sel_idx, 5'b00000} +: DAT_W];

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] to_cnt;

  // Count ACCESS cycles; cnt holds (cycles already spent) so the terminal
  // cycle is the TIMEOUT_CYCLES-th one
  always_ff @(posedge clk_i) begin
    if (!rst_i)                   to_cnt <= '0;
    else if (accept)              to_cnt <= '0;
    else if (state == ST_ACCESS)  to_cnt <= to_cnt + 1'b1;
  end

  assign timeout_hit = (state == ST_ACCESS) &&
                       (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_i) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; the selected ack wins over a coincident timeout
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (bus.m_stb_i) state_nxt = dec_valid ? ST_ACCESS : ST_DONE;
      ST_ACCESS: if (sel_ack || timeout_hit) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Request latch and completion data/status capture
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      sel_oh  <= '0;
      sel_idx <= 2'd0;
      s_we_q  <= 1'b0;
      s_adr_q <= '0;
      s_dat_q <= '0;
      m_dat_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      if (dec_valid) begin
        sel_oh  <= dec_oh;
        sel_idx <= dec_idx;
        s_we_q  <= bus.m_we_i;
        s_adr_q <= bus.m_adr_i;
        s_dat_q <= bus.m_dat_i;
        err_q   <= 1'b0;
      end else begin
        m_dat_q <= ERR_RDATA;
        err_q   <= 1'b1;
      end
    end else if (state == ST_ACCESS) begin
      if (sel_ack) begin
        m_dat_q <= s_we_q ? '0 : sel_rdata;
        err_q   <= 1'b0;
      end else if (timeout_hit) begin
        m_dat_q <= ERR_RDATA;
        err_q   <= 1'b1;
      end
    end
  end

  // Outputs decoded from state; strobe only while in ACCESS
  always_comb begin
    bus.m_ack_o = (state == ST_DONE);
    bus.m_err_o = (state == ST_DONE) && err_q;
    bus.m_dat_o = m_dat_q;
    bus.s_stb_o = (state == ST_ACCESS) ? sel_oh : '0;
    bus.s_we_o  = s_we_q;
    bus.s_adr_o = s_adr_q;
    bus.s_dat_o = s_dat_q;
  end

endmodule

// File: tb/tb_bus_ctrl.sv
// Directed scoreboard bench for bus_ctrl (TIMEOUT_CYCLES = 8).
module tb_bus_ctrl;

  localparam int TO_CYC = 8;
`ifdef BUS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam logic [127:0] BG = 128'hD3D3D3D3_C2C2C2C2_B1B1B1B1_A0A0A0A0;

  typedef struct {
    logic [31:0] dat;
    logic        err;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  bus_if bif ();

  bus_ctrl #(.TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One master transaction; the selected slave acks on its ack_cycle-th strobe cycle
  task automatic access(input string tag, input logic we, input logic [31:0] adr,
                        input logic [31:0] dat, input int ack_cycle,
                        input logic [31:0] rdata, input logic [3:0] noise);
    exp_t e, g;
    logic mapped, got;
    logic [3:0] oh;
    int idx, lat;
    mapped = (adr[31:28] < 4'd4);
    idx    = int'(adr[29:28]);
    oh     = mapped ? (4'b0001 << idx) : 4'b0000;
    if (!mapped) begin
      e.dat = 32'h0; e.err = 1'b1; e.lat = 0;
    end else if (TO_EN && ack_cycle > TO_CYC) begin
      e.dat = 32'h0; e.err = 1'b1; e.lat = TO_CYC;
    end else begin
      e.dat = we ? 32'h0 : rdata; e.err = 1'b0; e.lat = ack_cycle;
    end
    sb.push_back(e);

    bif.m_stb_i = 1'b1;
    bif.m_we_i  = we;
    bif.m_adr_i = adr;
    bif.m_dat_i = dat;
    bif.s_ack_i = noise;
    bif.s_dat_i = BG;
    tick();
    got = bif.m_ack_o;
    lat = 0;
    if (mapped) begin
      check({tag, "/s_adr"}, bif.s_adr_o, adr);
      check({tag, "/s_we"},  bif.s_we_o,  we);
      check({tag, "/s_dat"}, bif.s_dat_o, dat);
    end
    while (!got && lat < 40) begin
      lat++;
      check({tag, "/s_stb"}, bif.s_stb_o, oh);
      bif.s_dat_i = BG;
      if (lat == ack_cycle) begin
        bif.s_ack_i = noise | oh;
        bif.s_dat_i[idx*32 +: 32] = rdata;
      end
      tick();
      bif.s_ack_i = noise;
      bif.s_dat_i = BG;
      got = bif.m_ack_o;
    end
    bif.s_ack_i = 4'b0000;
    if (!got) begin
      check({tag, "/ack_timeout"}, 32'h0, 32'h1);
      void'(sb.pop_front());
    end else begin
      g = sb.pop_front();
      check({tag, "/latency"}, lat, g.lat);
      check({tag, "/m_dat"},   bif.m_dat_o, g.dat);
      check({tag, "/m_err"},   bif.m_err_o, g.err);
      check({tag, "/stb_done"}, bif.s_stb_o, 4'b0000);
    end
    // Strobe left high across the DONE edge must not start a new access
    tick();
    bif.m_stb_i = 1'b0;
    check({tag, "/ack_1cyc"}, bif.m_ack_o, 1'b0);
    check({tag, "/stb_idle"}, bif.s_stb_o, 4'b0000);
    check({tag, "/dat_hold"}, bif.m_dat_o, e.dat);
  endtask

  initial begin
    rst_n       = 1'b0;
    bif.m_stb_i = 1'b1;
    bif.m_we_i  = 1'b1;
    bif.m_adr_i = 32'h1000_0000;
    bif.m_dat_i = 32'h1234_5678;
    bif.s_ack_i = 4'hF;
    bif.s_dat_i = BG;
    tick();
    tick();
    check("rst/m_ack", bif.m_ack_o, 1'b0);
    check("rst/m_err", bif.m_err_o, 1'b0);
    check("rst/m_dat", bif.m_dat_o, 32'h0);
    check("rst/s_stb", bif.s_stb_o, 4'b0000);
    check("rst/s_adr", bif.s_adr_o, 32'h0);
    check("rst/s_dat", bif.s_dat_o, 32'h0);
    check("rst/s_we",  bif.s_we_o,  1'b0);
    rst_n       = 1'b1;
    bif.m_stb_i = 1'b0;
    bif.s_ack_i = 4'b0000;
    tick();

    // Stray acks while idle
    bif.s_ack_i = 4'hF;
    tick();
    bif.s_ack_i = 4'b0000;
    check("idle_ack/m_ack", bif.m_ack_o, 1'b0);
    check("idle_ack/s_stb", bif.s_stb_o, 4'b0000);
    tick();
    check("idle_ack/m_ack2", bif.m_ack_o, 1'b0);

    access("rd_ram",      1'b0, 32'h1000_0010, 32'h0,         3,  32'hCAFE_F00D, 4'b0000);
    access("wr_gpio",     1'b1, 32'h2000_0004, 32'h0000_00FF, 1,  32'hFFFF_FFFF, 4'b0000);
    access("rd_unmap",    1'b0, 32'h8000_0000, 32'h0,         1,  32'h1111_1111, 4'b0000);
    access("wr_unmap",    1'b1, 32'h4000_0000, 32'hAAAA_AAAA, 1,  32'h2222_2222, 4'b0000);
    access("rd_rom_noise",1'b0, 32'h0000_0100, 32'h0,         4,  32'h1234_5678, 4'b0100);
    access("rd_uart_late",1'b0, 32'h3000_0008, 32'h0,         21, 32'hDEAD_BEEF, 4'b0111);
    access("rd_uart_c8",  1'b0, 32'h3000_000C, 32'h0,         TO_CYC, 32'h55AA_55AA, 4'b0000);
    access("rd_ram_min",  1'b0, 32'h1000_0000, 32'h0,         1,  32'h0BAD_C0DE, 4'b0000);

    // Reset in the middle of an access, with the slave acking on the reset edge
    bif.m_stb_i = 1'b1;
    bif.m_we_i  = 1'b0;
    bif.m_adr_i = 32'h1000_0020;
    tick();
    check("abort/s_stb_pre", bif.s_stb_o, 4'b0010);
    tick();
    rst_n       = 1'b0;
    bif.m_stb_i = 1'b0;
    bif.s_ack_i = 4'b0010;
    bif.s_dat_i = BG;
    tick();
    rst_n       = 1'b1;
    bif.s_ack_i = 4'b0000;
    check("abort/s_stb", bif.s_stb_o, 4'b0000);
    check("abort/m_ack", bif.m_ack_o, 1'b0);
    check("abort/s_adr", bif.s_adr_o, 32'h0);
    check("abort/m_dat", bif.m_dat_o, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort/no_ack", bif.m_ack_o, 1'b0);
      check("abort/idle_stb", bif.s_stb_o, 4'b0000);
    end

    access("wr_uart_rec", 1'b1, 32'h3000_0000, 32'h600D_D00D, 2, 32'h3333_3333, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
